// File: rtl/timer_mmss.sv
// Three-digit BCD cook timer (M:ST:SO), shift-in keypad load, 1 s/edge countdown.
// Optional TIMER_DONE_PULSE_EN adds a registered one-cycle done pulse on reaching 0:00.
module timer_mmss #(
    parameter int MIN_MAX = 9,
    parameter int ST_MAX  = 5
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       EN,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       zero
`ifdef TIMER_DONE_PULSE_EN
    ,
    output logic       done
`endif
);

    localparam logic [3:0] MIN_LIM  = 4'(MIN_MAX);
    localparam logic [3:0] ST_LIM   = 4'(ST_MAX);
    localparam logic [3:0] ONES_LIM = 4'd9;

    logic [3:0] ones_d;
    logic [3:0] tens_d;
    logic [3:0] mins_d;
    logic       step;

    assign zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == 4'd0);
    assign step = loadn && EN && !zero;

    always_comb begin
        ones_d = sec_ones;
        tens_d = sec_tens;
        mins_d = mins;
        if (!loadn) begin
            // Digits move left one place, each clamped to its new position's range
            mins_d = (sec_tens > MIN_LIM) ? MIN_LIM : sec_tens;
            tens_d = (sec_ones > ST_LIM) ? ST_LIM : sec_ones;
            ones_d = (data > ONES_LIM) ? ONES_LIM : data;
        end else if (step) begin
            if (sec_ones != 4'd0) begin
                ones_d = sec_ones - 4'd1;
            end else if (sec_tens != 4'd0) begin
                ones_d = ONES_LIM;
                tens_d = sec_tens - 4'd1;
            end else begin
                ones_d = ONES_LIM;
                tens_d = ST_LIM;
                mins_d = mins - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clearn) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            mins     <= 4'd0;
        end else begin
            sec_ones <= ones_d;
            sec_tens <= tens_d;
            mins     <= mins_d;
        end
    end

`ifdef TIMER_DONE_PULSE_EN
    always_ff @(posedge clk) begin
        if (!clearn) begin
            done <= 1'b0;
        end else begin
            done <= step && (mins == 4'd0) && (sec_tens == 4'd0)
                    && (sec_ones == 4'd1);
        end
    end
`endif

endmodule

// File: tb/tb_timer_mmss.sv
// Self-checking bench for timer_mmss: seconds-based reference model plus
// directed vectors with literal expectations.
module tb_timer_mmss;

    logic       clk = 1'b0;
    logic       clearn = 1'b1;
    logic [3:0] data = 4'd0;
    logic       loadn = 1'b1;
    logic       EN = 1'b0;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;
`ifdef TIMER_DONE_PULSE_EN
    logic       done;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int  m_m = 0;
    int  m_t = 0;
    int  m_o = 0;
    bit  m_done = 1'b0;
    bit  m_valid = 1'b0;

    timer_mmss dut (
        .clk      (clk),
        .clearn   (clearn),
        .data     (data),
        .loadn    (loadn),
        .EN       (EN),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero)
`ifdef TIMER_DONE_PULSE_EN
        ,
        .done     (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // model: count steps are done on total seconds, loads on digits
    always @(posedge clk) begin
        int tot;
        if (!clearn) begin
            m_m = 0; m_t = 0; m_o = 0;
            m_done = 1'b0;
            m_valid = 1'b1;
        end else if (!loadn) begin
            m_m = (m_t > 9) ? 9 : m_t;
            m_t = (m_o > 5) ? 5 : m_o;
            m_o = (int'(data) > 9) ? 9 : int'(data);
            m_done = 1'b0;
        end else begin
            tot = m_m * 60 + m_t * 10 + m_o;
            m_done = 1'b0;
            if (EN && tot != 0) begin
                m_done = (tot == 1);
                tot = tot - 1;
                m_m = tot / 60;
                m_t = (tot % 60) / 10;
                m_o = tot % 10;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ones", sec_ones, 4'(m_o));
            chk("model_tens", sec_tens, 4'(m_t));
            chk("model_mins", mins, 4'(m_m));
            chk("model_zero", {3'b0, zero},
                {3'b0, (m_m == 0 && m_t == 0 && m_o == 0)});
`ifdef TIMER_DONE_PULSE_EN
            chk("model_done", {3'b0, done}, {3'b0, m_done});
`endif
        end
    end

    task automatic cyc(input logic c, input logic l, input logic [3:0] d,
                       input logic e);
        clearn = c;
        loadn  = l;
        data   = d;
        EN     = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 4'd0, 1'b1);
    endtask

    task automatic lit(input string nm, input int m, input int t,
                       input int o, input bit z);
        chk({nm, "_m"}, mins, 4'(m));
        chk({nm, "_t"}, sec_tens, 4'(t));
        chk({nm, "_o"}, sec_ones, 4'(o));
        chk({nm, "_z"}, {3'b0, zero}, {3'b0, z});
    endtask

    initial begin
        int seq [7];
        seq = '{4, 3, 2, 1, 0, 0, 0};
        @(negedge clk);
        cyc(1'b0, 1'b1, 4'd0, 1'b0);
        lit("reset", 0, 0, 0, 1'b1);
        run(3);
        lit("zero_hold", 0, 0, 0, 1'b1);

        cyc(1'b1, 1'b0, 4'd1, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b0);
        lit("load130", 1, 3, 0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 4'd0, 1'b0);
        lit("hold130", 1, 3, 0, 1'b0);

        run(30);
        lit("at100", 1, 0, 0, 1'b0);
        run(1);
        lit("borrow059", 0, 5, 9, 1'b0);
        run(59);
        lit("done000", 0, 0, 0, 1'b1);

        cyc(1'b1, 1'b0, 4'd5, 1'b0);
        lit("load005", 0, 0, 5, 1'b0);
        for (int i = 0; i < 7; i++) begin
            run(1);
            lit("nowrap", 0, 0, seq[i], (seq[i] == 0));
`ifdef TIMER_DONE_PULSE_EN
            chk("done_pulse", {3'b0, done}, {3'b0, (i == 4)});
`endif
        end

        cyc(1'b1, 1'b0, 4'hC, 1'b0);
        lit("sat_ones", 0, 0, 9, 1'b0);

        cyc(1'b0, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 1'b0);
        cyc(1'b1, 1'b0, 4'd2, 1'b0);
        lit("sat_tens", 0, 5, 2, 1'b0);

        cyc(1'b0, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b1);
`ifdef TIMER_DONE_PULSE_EN
        chk("no_done_load0", {3'b0, done}, 4'd0);
`endif
        cyc(1'b1, 1'b0, 4'd4, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b0);
        lit("load040", 0, 4, 0, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, 1'b1);
        lit("midload", 4, 0, 3, 1'b0);
        run(1);
        lit("resume", 4, 0, 2, 1'b0);
        run(3);
        lit("minborrow", 3, 5, 9, 1'b0);
        cyc(1'b0, 1'b0, 4'd8, 1'b1);
        lit("clr_over_load", 0, 0, 0, 1'b1);
        run(2);
        lit("stopped", 0, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
